spi_slave_core: RTL and testbench

SPI mode-0 slave that oversamples SCK, MOSI and CS with the system clock and deserialises 8-bit words, least-significant bit first. It sits between the board's SPI pins and the user logic. It presents each received byte with a one-cycle valid strobe, shifts a transmit byte out on MISO, and drives the LED bank from the last received byte.

---
 rtl/spi_slave_pkg.sv | 13 +
 rtl/spi_pin_sync.sv | 31 +++
 rtl/spi_slave_core.sv | 123 ++++++++++++
 tb/tb_spi_slave_core.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared constants and helpers for the SPI slave core.
package spi_slave_pkg;

    localparam int BYTE_W          = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int BIT_CNT_W       = $clog2(BYTE_W);

    // Counter width for an arbitrary word width; never narrower than 1 bit.
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop pin synchroniser with a trailing edge-detect register.
module spi_pin_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] sync;
    logic              q_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync <= {STAGES{RST_VAL}};
            q_d  <= RST_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], i_d};
            q_d  <= sync[STAGES-1];
        end
    end

    assign o_q    = sync[STAGES-1];
    assign o_rise = o_q & ~q_d;
    assign o_fall = ~o_q & q_d;

endmodule

// File: rtl/spi_slave_core.sv
// SPI mode-0 slave: oversampled pins, word deserialiser, MISO shifter, LEDs.
module spi_slave_core
    import spi_slave_pkg::*;
#(
    parameter int DATA_W      = BYTE_W,
    parameter bit LSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int LED_W       = 5
) (
    input  logic              i_clk,
    input  logic              i_sys_rst,
    input  logic              i_sck,
    input  logic              i_MOSI,
    input  logic              i_cs,
    input  logic [DATA_W-1:0] i_tx_byte,
    output logic              o_MISO,
    output logic [DATA_W-1:0] o_rx_byte,
    output logic              o_rx_dv,
    output logic [LED_W-1:0]  o_leds
);

    localparam int CNT_W = cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic sck_q, sck_rise, sck_fall;
    logic mosi_q, mosi_rise, mosi_fall;
    logic cs_q, cs_rise, cs_fall;
    logic cs_active;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .i_clk  (i_clk),
        .i_rst  (i_sys_rst),
        .i_d    (i_sck),
        .o_q    (sck_q),
        .o_rise (sck_rise),
        .o_fall (sck_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
        .i_clk  (i_clk),
        .i_rst  (i_sys_rst),
        .i_d    (i_MOSI),
        .o_q    (mosi_q),
        .o_rise (mosi_rise),
        .o_fall (mosi_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .i_clk  (i_clk),
        .i_rst  (i_sys_rst),
        .i_d    (i_cs),
        .o_q    (cs_q),
        .o_rise (cs_rise),
        .o_fall (cs_fall)
    );

    logic unused_edges;
    assign unused_edges = &{1'b0, sck_q, mosi_rise, mosi_fall, cs_rise};

    assign cs_active = ~cs_q;

    logic [CNT_W-1:0]  bit_cnt, cnt_n;
    logic [DATA_W-1:0] rx_shift, rx_n;
    logic [DATA_W-1:0] tx_shift, tx_n;
    logic              word_done, done_n;
    logic              tx_bit;

    assign tx_bit = LSB_FIRST ? tx_shift[0] : tx_shift[DATA_W-1];

    // Frame start is applied before a coincident SCK rise, so that bit
    // lands in the freshly cleared register as bit 0.
    always_comb begin
        cnt_n  = bit_cnt;
        rx_n   = rx_shift;
        tx_n   = tx_shift;
        done_n = 1'b0;
        if (cs_fall) begin
            cnt_n = '0;
            rx_n  = '0;
            tx_n  = i_tx_byte;
        end
        if (cs_active && sck_rise) begin
            rx_n = LSB_FIRST ? {mosi_q, rx_n[DATA_W-1:1]}
                             : {rx_n[DATA_W-2:0], mosi_q};
            if (cnt_n == LAST) begin
                cnt_n  = '0;
                done_n = 1'b1;
                tx_n   = i_tx_byte;
            end else begin
                cnt_n = cnt_n + CNT_W'(1);
            end
        end else if (cs_active && sck_fall && bit_cnt != '0) begin
            // The fall after a word's last rise must not consume the reload.
            tx_n = LSB_FIRST ? {1'b0, tx_n[DATA_W-1:1]}
                             : {tx_n[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge i_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            word_done <= 1'b0;
            o_rx_byte <= '0;
            o_rx_dv   <= 1'b0;
            o_leds    <= '0;
            o_MISO    <= 1'b0;
        end else begin
            bit_cnt   <= cnt_n;
            rx_shift  <= rx_n;
            tx_shift  <= tx_n;
            word_done <= done_n;
            o_rx_dv   <= word_done;
            o_MISO    <= cs_active & tx_bit;
            if (word_done) begin
                o_rx_byte <= rx_shift;
                o_leds    <= rx_shift[LED_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: SCK at clk/8, LSB-first words.
module tb_spi_slave_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       sck;
    logic       mosi;
    logic       cs;
    logic [7:0] tx_byte;
    logic       miso;
    logic [7:0] rx_byte;
    logic       rx_dv;
    logic [4:0] leds;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] dv_q[$];
    logic [7:0] miso_cap;
    logic       prev_dv = 1'b0;

    always #5 clk = ~clk;

    spi_slave_core dut (
        .i_clk     (clk),
        .i_sys_rst (rst),
        .i_sck     (sck),
        .i_MOSI    (mosi),
        .i_cs      (cs),
        .i_tx_byte (tx_byte),
        .o_MISO    (miso),
        .o_rx_byte (rx_byte),
        .o_rx_dv   (rx_dv),
        .o_leds    (leds)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_dv === 1'b1) begin
            chk("dv_one_cycle", {31'd0, prev_dv}, 32'd0);
            dv_q.push_back(rx_byte);
        end
        prev_dv = rx_dv;
    end

    task automatic cs_on();
        cs = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_off();
        repeat (4) @(negedge clk);
        cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            mosi = b[i];
            repeat (4) @(negedge clk);
            miso_cap[i] = miso;
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0; tx_byte = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_rx_byte", rx_byte, 32'h00);
        chk("rst_rx_dv", rx_dv, 32'h0);
        chk("rst_leds", leds, 32'h00);
        chk("rst_miso", miso, 32'h0);
        rst = 1'b0;

        // SCK toggling with CS high must be ignored
        for (int i = 0; i < 4; i++) begin
            mosi = 1'b1;
            repeat (4) @(negedge clk); sck = 1'b1;
            repeat (4) @(negedge clk); sck = 1'b0;
        end
        repeat (8) @(negedge clk);
        chk("idle_dv_count", dv_q.size(), 32'd0);
        chk("idle_rx_byte", rx_byte, 32'h00);
        chk("idle_miso", miso, 32'h0);

        // Single word 0xA5
        dv_q.delete();
        cs_on(); send_bits(8'hA5, 8); cs_off();
        chk("a5_dv_count", dv_q.size(), 32'd1);
        chk("a5_dv_value", dv_q[0], 32'hA5);
        chk("a5_rx_byte", rx_byte, 32'hA5);
        chk("a5_leds", leds, 32'h05);

        // Back-to-back 0x3C, 0xFF in one frame
        dv_q.delete();
        cs_on(); send_bits(8'h3C, 8); send_bits(8'hFF, 8); cs_off();
        chk("b2b_dv_count", dv_q.size(), 32'd2);
        chk("b2b_first", dv_q[0], 32'h3C);
        chk("b2b_second", dv_q[1], 32'hFF);
        chk("b2b_leds", leds, 32'h1F);

        // Transmit 0x96 while receiving 0x5A
        dv_q.delete();
        tx_byte = 8'h96;
        cs_on(); send_bits(8'h5A, 8);
        chk("tx_miso_word", miso_cap, 32'h96);
        cs_off();
        chk("tx_dv_value", dv_q[0], 32'h5A);
        chk("tx_idle_miso", miso, 32'h0);

        // Abort after 5 bits of 0x81, then 0x42
        dv_q.delete();
        cs_on(); send_bits(8'h81, 5); cs_off();
        chk("abort_dv_count", dv_q.size(), 32'd0);
        chk("abort_rx_byte", rx_byte, 32'h5A);
        cs_on(); send_bits(8'h42, 8); cs_off();
        chk("after_abort_count", dv_q.size(), 32'd1);
        chk("after_abort_value", dv_q[0], 32'h42);
        chk("after_abort_leds", leds, 32'h02);

        // Reset mid-word during 0x77, then 0x18 in a new frame
        cs_on(); send_bits(8'h77, 3);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_rx_byte", rx_byte, 32'h00);
        chk("midrst_leds", leds, 32'h00);
        chk("midrst_miso", miso, 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        cs = 1'b1;
        repeat (8) @(negedge clk);
        dv_q.delete();
        cs_on(); send_bits(8'h18, 8); cs_off();
        chk("post_rst_count", dv_q.size(), 32'd1);
        chk("post_rst_value", dv_q[0], 32'h18);
        chk("post_rst_rx_byte", rx_byte, 32'h18);
        chk("post_rst_leds", leds, 32'h18);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
